// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between ICache refill and DCache miss paths.
// Optional performance counters are enabled by defining AXI_ARB_PERF_EN.
module axi_read_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ic_arvalid,
    output logic                  ic_arready,
    input  logic [ADDR_WIDTH-1:0] ic_araddr,
    input  logic [ID_WIDTH-1:0]   ic_arid,
    input  logic [LEN_WIDTH-1:0]  ic_arlen,
    input  logic [2:0]            ic_arsize,
    input  logic [1:0]            ic_arburst,
    output logic                  ic_rvalid,
    input  logic                  ic_rready,

    input  logic                  dc_arvalid,
    output logic                  dc_arready,
    input  logic [ADDR_WIDTH-1:0] dc_araddr,
    input  logic [ID_WIDTH-1:0]   dc_arid,
    input  logic [LEN_WIDTH-1:0]  dc_arlen,
    input  logic [2:0]            dc_arsize,
    input  logic [1:0]            dc_arburst,
    output logic                  dc_rvalid,
    input  logic                  dc_rready,

    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [ID_WIDTH-1:0]   m_arid,
    output logic [LEN_WIDTH-1:0]  m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [ID_WIDTH-1:0]   m_rid,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,

    output logic [DATA_WIDTH-1:0] r_data,
    output logic [ID_WIDTH-1:0]   r_id,
    output logic [1:0]            r_resp,
    output logic                  r_last,
    output logic                  protocol_err
`ifdef AXI_ARB_PERF_EN
    ,
    output logic [31:0]           perf_ic_grant,
    output logic [31:0]           perf_dc_grant,
    output logic [31:0]           perf_wait
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    // Master index 0 is the ICache, 1 is the DCache.
    logic [1:0]            state_reg, state_next;
    logic                  grant_reg, grant_next;
    logic                  rr_last_reg, rr_last_next;
    logic [LEN_WIDTH-1:0]  len_q_reg, len_q_next;
    logic [LEN_WIDTH:0]    beat_cnt_reg, beat_cnt_next;
    logic                  protocol_err_reg, protocol_err_next;

    logic [1:0]            arvalid_vec;
    logic [1:0]            rready_vec;
    logic [1:0]            arready_vec;
    logic [1:0]            rvalid_vec;
    logic [ADDR_WIDTH-1:0] araddr_arr  [2];
    logic [ID_WIDTH-1:0]   arid_arr    [2];
    logic [LEN_WIDTH-1:0]  arlen_arr   [2];
    logic [2:0]            arsize_arr  [2];
    logic [1:0]            arburst_arr [2];

    logic                  gnt_arvalid;
    logic                  gnt_rready;
    logic                  ar_hs;
    logic                  r_beat;

    assign arvalid_vec    = {dc_arvalid, ic_arvalid};
    assign rready_vec     = {dc_rready, ic_rready};
    assign araddr_arr[0]  = ic_araddr;
    assign araddr_arr[1]  = dc_araddr;
    assign arid_arr[0]    = ic_arid;
    assign arid_arr[1]    = dc_arid;
    assign arlen_arr[0]   = ic_arlen;
    assign arlen_arr[1]   = dc_arlen;
    assign arsize_arr[0]  = ic_arsize;
    assign arsize_arr[1]  = dc_arsize;
    assign arburst_arr[0] = ic_arburst;
    assign arburst_arr[1] = dc_arburst;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_route
            localparam logic IDX = 1'(gi);
            assign arready_vec[gi] = (state_reg == ADDR) && (grant_reg == IDX) && m_arready;
            assign rvalid_vec[gi]  = (state_reg == DATA) && (grant_reg == IDX) && m_rvalid;
        end
    endgenerate

    assign ic_arready = arready_vec[0];
    assign dc_arready = arready_vec[1];
    assign ic_rvalid  = rvalid_vec[0];
    assign dc_rvalid  = rvalid_vec[1];

    assign gnt_arvalid = arvalid_vec[grant_reg];
    assign gnt_rready  = rready_vec[grant_reg];

    assign m_arvalid = (state_reg == ADDR) && gnt_arvalid;
    assign m_araddr  = araddr_arr[grant_reg];
    assign m_arid    = arid_arr[grant_reg];
    assign m_arlen   = arlen_arr[grant_reg];
    assign m_arsize  = arsize_arr[grant_reg];
    assign m_arburst = arburst_arr[grant_reg];
    assign m_rready  = (state_reg == DATA) && gnt_rready;

    // Data-side fields go straight through; each cache qualifies them with its own rvalid.
    assign r_data = m_rdata;
    assign r_id   = m_rid;
    assign r_resp = m_rresp;
    assign r_last = m_rlast;

    assign protocol_err = protocol_err_reg;

    assign ar_hs  = m_arvalid && m_arready;
    assign r_beat = m_rvalid && m_rready;

    always_comb begin
        state_next        = state_reg;
        grant_next        = grant_reg;
        rr_last_next      = rr_last_reg;
        len_q_next        = len_q_reg;
        beat_cnt_next     = beat_cnt_reg;
        protocol_err_next = protocol_err_reg;
        case (state_reg)
            IDLE: begin
                if (|arvalid_vec) begin
                    grant_next = (arvalid_vec == 2'b11) ? ~rr_last_reg : arvalid_vec[1];
                    len_q_next = arlen_arr[grant_next];
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (ar_hs) begin
                    state_next    = DATA;
                    beat_cnt_next = '0;
                end
            end
            DATA: begin
                if (r_beat) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                    if (m_rlast) begin
                        rr_last_next = grant_reg;
                        state_next   = IDLE;
                        if (beat_cnt_reg != {1'b0, len_q_reg}) begin
                            protocol_err_next = 1'b1;
                        end
                    end else if (beat_cnt_reg == {1'b0, len_q_reg}) begin
                        // Final expected beat without rlast: flag it and keep waiting for rlast.
                        protocol_err_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg        <= IDLE;
            grant_reg        <= 1'b0;
            rr_last_reg      <= 1'b1;
            len_q_reg        <= '0;
            beat_cnt_reg     <= '0;
            protocol_err_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            grant_reg        <= grant_next;
            rr_last_reg      <= rr_last_next;
            len_q_reg        <= len_q_next;
            beat_cnt_reg     <= beat_cnt_next;
            protocol_err_reg <= protocol_err_next;
        end
    end

`ifdef AXI_ARB_PERF_EN
    logic [31:0] perf_ic_grant_reg;
    logic [31:0] perf_dc_grant_reg;
    logic [31:0] perf_wait_reg;
    logic        wait_now;

    // In IDLE only a tie leaves someone waiting; otherwise the non-granted master waits.
    assign wait_now = (state_reg == IDLE) ? (&arvalid_vec) : arvalid_vec[~grant_reg];

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_ic_grant_reg <= '0;
            perf_dc_grant_reg <= '0;
            perf_wait_reg     <= '0;
        end else begin
            if (ar_hs && !grant_reg) perf_ic_grant_reg <= perf_ic_grant_reg + 32'd1;
            if (ar_hs && grant_reg)  perf_dc_grant_reg <= perf_dc_grant_reg + 32'd1;
            if (wait_now)            perf_wait_reg     <= perf_wait_reg + 32'd1;
        end
    end

    assign perf_ic_grant = perf_ic_grant_reg;
    assign perf_dc_grant = perf_dc_grant_reg;
    assign perf_wait     = perf_wait_reg;
`endif

    // A granted master must keep arvalid high until its AR handshake completes.
    ar_hold_chk: assert property (@(posedge clk) disable iff (!rst)
        (state_reg == ADDR) |-> gnt_arvalid);

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
Shares one AXI read channel (AR/R) between the ICache refill path and the DCache miss path. The ICache refill path uses the cache modport of ICacheAxi; the DCache miss path uses the miss modport of DCacheAxi. Round-robin arbitration, one outstanding burst at a time, full R-beat routing back to the granted cache. The block sits between the two cache AXI read ports and the memory-side AXI master port.

Parameters:
ADDR_WIDTH, 32, AR address width
DATA_WIDTH, 64, R data width
ID_WIDTH, 4, AR/R ID width
LEN_WIDTH, 8, AXI arlen width

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low
ic_arvalid  input  1  ICache AR valid
ic_arready  output  1  ICache AR ready
ic_araddr  input  ADDR_WIDTH  ICache AR address
ic_arid  input  ID_WIDTH  ICache AR ID
ic_arlen  input  LEN_WIDTH  ICache burst length minus 1
ic_arsize  input  3  ICache beat size
ic_arburst  input  2  ICache burst type
ic_rvalid  output  1  ICache R valid
ic_rready  input  1  ICache R ready
dc_arvalid, dc_arready, dc_araddr, dc_arid, dc_arlen, dc_arsize, dc_arburst  as ic_*  DCache AR channel
dc_rvalid, dc_rready  as ic_*  DCache R handshake
m_arvalid  output  1  memory AR valid
m_arready  input  1  memory AR ready
m_araddr, m_arid, m_arlen, m_arsize, m_arburst  output  as above  muxed AR fields
m_rvalid  input  1  memory R valid
m_rready  output  1  memory R ready
m_rdata  input  DATA_WIDTH  R data, fanned out to both caches
m_rid  input  ID_WIDTH  R ID, fanned out
m_rresp  input  2  R response, fanned out
m_rlast  input  1  R last, fanned out
r_data/r_id/r_resp/r_last  output  as m_*  registered-free passthrough to both caches
protocol_err  output  1  sticky: beat count mismatch with arlen

Behaviour:
- FSM states: IDLE, ADDR, DATA. Reset (rst=0 at a clk edge) forces:
  - state=IDLE, grant=ICache, rr_last=DCache (so ICache wins the first tie), beat_cnt=0, protocol_err=0.
  - All valid/ready outputs 0.
- IDLE:
  - If exactly one arvalid is high, grant that master.
  - If both are high, grant the master that is not rr_last.
  - Latch the granted master's arlen into len_q; go to ADDR next cycle.
  - With no request, stay in IDLE.
  - Arbitration latency is one cycle: m_arvalid is never asserted in the request's first cycle.
- ADDR:
  - m_arvalid = granted arvalid; m_ar* are combinationally muxed from the granted master.
  - Granted x_arready = m_arready. The non-granted arready stays 0.
  - On m_arvalid & m_arready, go to DATA with beat_cnt=0.
  - If the granted master drops arvalid before the handshake (AXI violation), the grant is held and m_arvalid follows it low. A simulation assertion fires.
- DATA:
  - Granted x_rvalid = m_rvalid; m_rready = granted x_rready. The non-granted rvalid stays 0.
  - Each beat (m_rvalid & m_rready) increments beat_cnt, width LEN_WIDTH+1, so len=255 does not wrap.
  - On a beat with m_rlast=1: rr_last <= grant, state <= IDLE.
  - If beat_cnt != len_q on that rlast beat, set protocol_err (sticky until reset).
  - If beat_cnt == len_q on a beat without rlast, also set protocol_err. The FSM stays in DATA until rlast arrives.
- A new AR is never issued before the rlast beat of the current burst; returning to IDLE costs one bubble cycle.
- A request arriving during ADDR/DATA waits; the arbiter re-evaluates in IDLE.
- Back-to-back contention alternates masters: IC, DC, IC...
- r_data/r_id/r_resp/r_last are pure wires from m_*; consumers qualify them with their own rvalid.
- Reset mid-burst drops the transaction with no completion signalled; the memory side is reset together.

Optional Feature:
AXI_ARB_PERF_EN:
- When defined, adds outputs perf_ic_grant[31:0], perf_dc_grant[31:0] and perf_wait[31:0].
  - perf_ic_grant and perf_dc_grant increment on each AR handshake of the respective master.
  - perf_wait increments on every cycle in which a non-granted master has arvalid=1.
  - All three reset to 0 and wrap at 2^32.
- When not defined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Single ICache request: araddr=0x8000_0000, arlen=3, DCache idle.
  - m_arvalid rises one cycle after ic_arvalid.
  - Exactly 4 beats route to ic_rvalid; dc_rvalid stays 0.
  - FSM returns to IDLE; protocol_err=0.
- Both masters request in the same cycle after reset.
  - ICache is granted first, then DCache.
  - A second simultaneous pair grants ICache again: rr_last=DCache after the DCache burst.
- DCache request arrives during the ICache DATA phase.
  - dc_arready stays 0 until the ICache rlast beat.
  - DCache AR issues two cycles after that beat.
- Memory asserts m_rlast on beat 2 of an arlen=3 burst.
  - protocol_err=1 and stays 1 through later correct bursts until rst=0.
- Granted master holds rready=0 for 5 cycles mid-burst.
  - m_rready=0 during that window; no beat is lost; beat_cnt holds.
- Assert rst=0 in the DATA phase, then release.
  - All valids=0; state=IDLE.
  - The next simultaneous request grants ICache.
  - With AXI_ARB_PERF_EN, all counters read 0.
